hatch_ctrl: RTL

HATCH_CTRL -- requirements
Module: hatch_ctrl

---
 rtl/hatch_pkg.sv | 15 +
 rtl/hatch_ctrl_temp_ctrl.sv | 46 ++++
 rtl/hatch_ctrl.sv | 89 ++++++++
 3 files changed

// File: rtl/hatch_pkg.sv
// Shared definitions for the egg incubation controller: FSM states and display image indices.
package hatch_pkg;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_INCUBATE = 2'd1,
    S_HATCHED  = 2'd2,
    S_FAILED   = 2'd3
  } state_t;

  localparam logic [4:0] DZ_LAST_STAGE = 5'd15;
  localparam logic [4:0] DZ_HATCHED    = 5'd16;
  localparam logic [3:0] TEMP_MAX      = 4'd15;

endpackage

// File: rtl/hatch_ctrl_temp_ctrl.sv
// Saturating incubator temperature with periodic drift-down driven by the tick timebase.
module temp_ctrl
  import hatch_pkg::*;
#(
  parameter int DRIFT_TICKS = 2,
  parameter int TEMP_INIT   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       en,
  input  logic       up,
  input  logic       down,
  input  logic       tick,
  output logic [3:0] temp
);

  localparam int DW = (DRIFT_TICKS > 1) ? $clog2(DRIFT_TICKS) : 1;

  logic [DW-1:0] dcnt;
  logic          drift_ev;
  logic [3:0]    temp_nxt;
  int            t;

  assign drift_ev = tick && (dcnt == DW'(DRIFT_TICKS - 1));

  // up/down/drift combine into a single net step, clamped to the 4-bit range
  always_comb begin
    t = int'(temp) + int'(up) - int'(down) - int'(drift_ev);
    temp_nxt = temp;
    if (t < 0)                  temp_nxt = 4'd0;
    else if (t > int'(TEMP_MAX)) temp_nxt = TEMP_MAX;
    else                        temp_nxt = 4'(t);
  end

  always_ff @(posedge clk) begin
    if (rst || load) begin
      temp <= 4'(TEMP_INIT);
      dcnt <= '0;
    end else if (en) begin
      temp <= temp_nxt;
      if (tick) dcnt <= drift_ev ? '0 : dcnt + DW'(1);
    end
  end

endmodule

// File: rtl/hatch_ctrl.sv
// Incubation FSM: stages the egg image on tick, fails on unsafe temperature, strobes the display.
module hatch_ctrl
  import hatch_pkg::*;
#(
  parameter int STAGE_TICKS = 4,
  parameter int DRIFT_TICKS = 2,
  parameter int TEMP_INIT   = 8,
  parameter int TEMP_LO     = 3,
  parameter int TEMP_HI     = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       heat_up,
  input  logic       heat_down,
  input  logic       tick,
  output logic [4:0] dz_num,
  output logic       dst,
  output logic       fail,
  output logic [3:0] temp,
  output logic       busy
);

  localparam int SW = (STAGE_TICKS > 1) ? $clog2(STAGE_TICKS) : 1;

  state_t        state;
  logic [SW-1:0] scnt;
  logic          temp_bad;
  logic          stage_ev;

  temp_ctrl #(
    .DRIFT_TICKS(DRIFT_TICKS),
    .TEMP_INIT  (TEMP_INIT)
  ) u_temp (
    .clk (clk),
    .rst (rst),
    .load(start),
    .en  (busy),
    .up  (heat_up),
    .down(heat_down),
    .tick(tick),
    .temp(temp)
  );

  // judged on the registered temperature, so a bad value fails one cycle after it appears
  assign temp_bad = (temp < 4'(TEMP_LO)) || (temp > 4'(TEMP_HI));
  assign stage_ev = tick && (scnt == SW'(STAGE_TICKS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      dz_num <= '0;
      dst    <= 1'b0;
      fail   <= 1'b0;
      busy   <= 1'b0;
      scnt   <= '0;
    end else begin
      dst <= 1'b0;
      if (start) begin
        state  <= S_INCUBATE;
        dz_num <= '0;
        fail   <= 1'b0;
        busy   <= 1'b1;
        scnt   <= '0;
        dst    <= 1'b1;
      end else if (state == S_INCUBATE) begin
        if (temp_bad) begin
          state <= S_FAILED;
          fail  <= 1'b1;
          busy  <= 1'b0;
          dst   <= 1'b1;
        end else if (tick) begin
          scnt <= stage_ev ? '0 : scnt + SW'(1);
          if (stage_ev) begin
            dst <= 1'b1;
            if (dz_num == DZ_LAST_STAGE) begin
              dz_num <= DZ_HATCHED;
              state  <= S_HATCHED;
              busy   <= 1'b0;
            end else begin
              dz_num <= dz_num + 5'd1;
            end
          end
        end
      end
    end
  end

endmodule
